stream_feed_ctl: RTL

STREAM_FEED_CTL -- requirements
Module: stream_feed_ctl

---
 rtl/stream_feed_ctl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/stream_feed_ctl.sv
`default_nettype none
// ============================================================================
// Module   : stream_feed_ctl
// Purpose  : Byte feeder between a stream memory and a downstream decoder.
//            Fetches one byte at a time, holds it until the decoder accepts
//            it, and supports seeking. A seek flushes the in-flight byte and
//            holds the decoder in reset for FLUSH_CYC cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W        byte-address width of the stream memory
//   FLUSH_CYC     decoder reset hold time on seek and after reset (4..255)
// Ports
//   sys_clk       system clock, rising edge
//   rst           synchronous, active-low reset
//   run           1 = keep feeding, 0 = stop after the current byte
//   stream_len    number of valid bytes in the stream
//   seek_req      single-cycle jump request, with seek_addr
//   seek_addr     target byte index for the jump
//   mem_rd        one-cycle read strobe to stream memory, with mem_addr
//   mem_addr      read byte address
//   mem_dta       read data, qualified by mem_dta_valid
//   mem_dta_valid read data valid, one per mem_rd
//   busy          decoder backpressure
//   stream_data   byte to the decoder, qualified by stream_valid
//   stream_valid  byte strobe to the decoder
//   dec_rst_n     active-low decoder reset
//   byte_index    index of the next byte to fetch
//   eos           end of stream reached
//   seek_ack      one-cycle pulse when a seek completes
// ============================================================================
module stream_feed_ctl #(
  parameter int ADDR_W    = 23,
  parameter int FLUSH_CYC = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] stream_len,
  input  logic              seek_req,
  input  logic [ADDR_W-1:0] seek_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dta,
  input  logic              mem_dta_valid,
  input  logic              busy,
  output logic [7:0]        stream_data,
  output logic              stream_valid,
  output logic              dec_rst_n,
  output logic [ADDR_W-1:0] byte_index,
  output logic              eos,
  output logic              seek_ack
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    FLUSH   = 3'd4,
    EOS     = 3'd5
  } state_t;

  localparam logic [7:0]        CNT_LAST = 8'(FLUSH_CYC - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] len_q;     // stream_len as sampled on leaving IDLE / seek
  logic [ADDR_W-1:0] idx_inc;
  logic [7:0]        hold;      // fetched byte awaiting the decoder
  logic [7:0]        cnt;       // flush / post-reset decoder-reset timer
  logic              init_done; // post-reset decoder reset has elapsed
  logic              seek_take;
  logic              handoff;
  logic              cnt_done;

  assign idx_inc     = byte_index + IDX_ONE;
  assign cnt_done    = (cnt == CNT_LAST);
  assign stream_data = hold;

  // A seek is honoured everywhere except while a flush is already running.
  assign seek_take = seek_req && (state != FLUSH);

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    handoff      = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    stream_valid = 1'b0;
    eos          = 1'b0;
    seek_ack     = 1'b0;
    dec_rst_n    = init_done && (state != FLUSH);

    case (state)
      IDLE: begin
        // No fetch until the decoder has come out of its post-reset hold.
        if (init_done && run) begin
          state_nxt = (byte_index < stream_len) ? FETCH : EOS;
        end
      end
      FETCH: begin
        mem_rd    = 1'b1;
        mem_addr  = byte_index;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_dta_valid) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        // A coincident seek wins: the held byte is dropped, not presented.
        if (!busy && !seek_req) begin
          handoff      = 1'b1;
          stream_valid = 1'b1;
          if (idx_inc >= len_q) begin
            state_nxt = EOS;
          end else if (run) begin
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      FLUSH: begin
        // Any read data returning here belongs to an abandoned fetch.
        if (cnt_done) begin
          seek_ack = 1'b1;
          if (!run) begin
            state_nxt = IDLE;
          end else if (byte_index >= len_q) begin
            state_nxt = EOS;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      EOS: begin
        eos = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (seek_take) begin
      state_nxt = FLUSH;
    end
  end

  // --------------------------------------------------------------------------
  // State, index and data registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state      <= IDLE;
      byte_index <= '0;
      len_q      <= '0;
      hold       <= '0;
      cnt        <= '0;
      init_done  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (seek_take) begin
        byte_index <= seek_addr;
        len_q      <= stream_len;
      end else begin
        if (handoff) begin
          byte_index <= idx_inc;
        end
        if ((state == IDLE) && (state_nxt != IDLE)) begin
          len_q <= stream_len;
        end
      end

      if ((state == WAIT) && mem_dta_valid && !seek_take) begin
        hold <= mem_dta;
      end

      // One timer serves both the post-reset decoder hold and seek flushes.
      if (seek_take) begin
        cnt <= '0;
      end else if (state == FLUSH) begin
        if (cnt_done) begin
          cnt       <= '0;
          init_done <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else if (!init_done) begin
        if (cnt_done) begin
          init_done <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
